// File: rtl/byte_serial_adder.sv
// Multi-byte adder that reuses one 8-bit add slice, one byte per clock, with
// valid/ready handshakes on both the operand side and the result side.
module byte_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_r, b_r;

  logic             accept;
  logic             last_step;
  logic [IDX_W+2:0] shamt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [7:0]       a8, b8, s8;
  logic [8:0]       slice_sum;
  logic             c_into_msb;
  logic [WIDTH-1:0] byte_mask, s8_ext;

  function automatic logic [8:0] add_slice(input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
    add_slice = {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_step = (idx == LAST_IDX);

  // Byte selection: shift the active byte of each operand down to bit 0.
  assign shamt     = {idx, 3'b000};
  assign a_sh      = a_r >> shamt;
  assign b_sh      = b_r >> shamt;
  assign a8        = a_sh[7:0];
  assign b8        = b_sh[7:0];
  assign slice_sum = add_slice(a8, b8, carry);
  assign s8        = slice_sum[7:0];
  // Carry into bit 7 recovered from the sum bit and its two operand bits.
  assign c_into_msb = a8[7] ^ b8[7] ^ s8[7];
  assign byte_mask  = WIDTH'(8'hFF) << shamt;

  always_comb begin
    s8_ext      = '0;
    s8_ext[7:0] = s8;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture: only on an accepting edge, so RUN/HOLD ignore the inputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= A;
      b_r <= B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            carry <= Cin;
          end
        end
        RUN: begin
          S     <= (S & ~byte_mask) | (s8_ext << shamt);
          carry <= slice_sum[8];
          idx   <= idx + 1'b1;
          if (last_step) begin
            Cout <= slice_sum[8];
            ovf  <= c_into_msb ^ slice_sum[8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: directed vectors push expected
// results; a negedge monitor pops and compares on every result handshake.
module tb_byte_serial_adder;

  localparam int WIDTH   = 32;
  localparam int NBYTES  = WIDTH / 8;
  // accept cycle + NBYTES RUN cycles + one HOLD cycle -> next IDLE accept
  localparam int ISSUE_T = NBYTES + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0, B = '0;
  logic             Cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] S;
  logic             Cout, ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [WIDTH+1:0] sb[$];

  byte_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent reference: full-width add, overflow from operand/result signs.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    v    = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {full[WIDTH-1:0], full[WIDTH], v};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(S), 64'hDEAD);
      end else begin
        logic [WIDTH+1:0] e;
        e = sb.pop_front();
        chk("S",    64'(S),    64'(e[WIDTH+1:2]));
        chk("Cout", 64'(Cout), 64'(e[1]));
        chk("ovf",  64'(ovf),  64'(e[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo, input bit push);
    wait_ready();
    in_valid = 1'b1;
    A = a;
    B = b;
    Cin = c;
    if (push) sb.push_back({es, ec, eo});
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int last_acc;
    logic [WIDTH+1:0] e;
    logic [WIDTH-1:0] ra, rb;
    logic rc;

    // Reset state
    rst = 1'b1;
    step();
    chk("in_ready_during_rst", 64'(in_ready), 64'd0);
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_S",         64'(S),         64'd0);
    chk("rst_Cout",      64'(Cout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Byte-0 carry into byte 1, with exact latency
    out_ready = 1'b1;
    send(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < NBYTES; i++) begin
      step();
      chk("latency_not_yet", 64'(out_valid), 64'd0);
    end
    step();
    chk("latency_valid", 64'(out_valid), 64'd1);
    step();
    chk("hold_one_cycle", 64'(out_valid), 64'd0);

    // Carry ripples through every byte
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    // Signed overflow cases
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);

    // Backpressure: result must hold, new operands ignored
    wait_ready();
    out_ready = 1'b0;
    send(32'h0000A000, 32'h00000B00, 1'b1, 32'h0000AB01, 1'b0, 1'b0, 1'b1);
    wait_valid();
    in_valid = 1'b1;
    A = 32'hDEADBEEF;
    B = 32'h00000001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_S",         64'(S),         64'h0000AB01);
      chk("bp_Cout",      64'(Cout),      64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready),  64'd1);

    // Reset in the middle of RUN discards the transaction
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_S",         64'(S),         64'd0);
    chk("midrst_Cout",      64'(Cout),      64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    send(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b1);

    // Streaming: in_valid and out_ready both held high
    wait_ready();
    in_valid = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'hFFFFFFFF;
      A = ra;
      B = rb;
      Cin = rc;
      e = model(ra, rb, rc);
      sb.push_back(e);
      if (i > 0) chk("issue_interval", 64'(cyc - last_acc), 64'(ISSUE_T));
      last_acc = cyc;
      step();
    end
    in_valid = 1'b0;

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        step();
        n++;
      end
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
